// File: rtl/cpu_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_bus_arbiter_pkg
//  Purpose  : Shared encodings for the instruction/data bus arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_bus_arbiter_pkg;

  // Transaction sequencer states
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_t;

  // Which requester owns the transaction in flight
  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } arb_owner_t;

  // Access size encodings on the SRAM-like bus
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Wide enough for a starvation limit of up to 15
  localparam int STARVE_CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/cpu_bus_arbiter_starve_counter.sv
`default_nettype none
// ============================================================================
//  Module   : arb_starve_counter
//  Purpose  : Saturating count of data grants made while a fetch is waiting.
//  Revision : 1.0 - initial release
// ============================================================================
module arb_starve_counter
  import cpu_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_at_limit
);

  localparam logic [STARVE_CNT_W-1:0] C_LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] r_cnt;

  assign o_at_limit = (r_cnt == C_LIMIT);

  // Clear wins over increment; increment stops once the limit is reached
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !o_at_limit) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cpu_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_bus_arbiter
//  Purpose  : Shares one SRAM-like bus between instruction fetch and
//             load/store, one transaction at a time, and reports stalls.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_bus_arbiter
  import cpu_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch port
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [31:0]       inst_rdata,
  // load/store port
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [31:0]       data_rdata,
  // shared bus
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [31:0]       bus_rdata,
  // hazard unit
  output logic              stallreq_from_if,
  output logic              stallreq_from_mem
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  arb_owner_t r_owner;
  arb_owner_t w_owner_nxt;
  logic       w_bus_req_nxt;
  logic       w_grant_data;
  logic       w_grant_inst;
  logic       w_addr_ok;
  logic       w_data_ok;
  logic       w_starve_at_limit;
  logic       w_starve_inc;
  logic       w_starve_clr;

  // A fetch that has watched too many data grants go by wins the next slot
  assign w_starve_inc = w_grant_data & inst_req;
  assign w_starve_clr = w_grant_inst | ((r_state == ARB_IDLE) & ~inst_req);

  arb_starve_counter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_starve_clr),
    .i_inc      (w_starve_inc),
    .o_at_limit (w_starve_at_limit)
  );

  // Grant decision, phase sequencing and ok-pulse generation
  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_bus_req_nxt = bus_req;
    w_grant_data  = 1'b0;
    w_grant_inst  = 1'b0;
    w_addr_ok     = 1'b0;
    w_data_ok     = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (data_req && !(inst_req && w_starve_at_limit)) begin
          w_grant_data  = 1'b1;
          w_owner_nxt   = OWN_DATA;
          w_bus_req_nxt = 1'b1;
          w_state_nxt   = ARB_ADDR;
        end else if (inst_req) begin
          w_grant_inst  = 1'b1;
          w_owner_nxt   = OWN_INST;
          w_bus_req_nxt = 1'b1;
          w_state_nxt   = ARB_ADDR;
        end
      end
      ARB_ADDR: begin
        // a data_ok arriving together with addr_ok is deliberately dropped
        if (bus_addr_ok) begin
          w_addr_ok     = 1'b1;
          w_bus_req_nxt = 1'b0;
          w_state_nxt   = ARB_DATA;
        end
      end
      ARB_DATA: begin
        if (bus_data_ok) begin
          w_data_ok   = 1'b1;
          w_state_nxt = ARB_IDLE;
        end
      end
      default: begin
        w_bus_req_nxt = 1'b0;
        w_state_nxt   = ARB_IDLE;
      end
    endcase
  end

  // Sequencer state, owner and bus request registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ARB_IDLE;
      r_owner <= OWN_INST;
      bus_req <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      bus_req <= w_bus_req_nxt;
    end
  end

  // Capture the winner's request fields at grant; they stay put until the next grant
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus_wr    <= 1'b0;
      bus_size  <= 2'd0;
      bus_addr  <= '0;
      bus_wdata <= 32'd0;
    end else if (w_grant_data) begin
      bus_wr    <= data_wr;
      bus_size  <= data_size;
      bus_addr  <= data_addr;
      bus_wdata <= data_wdata;
    end else if (w_grant_inst) begin
      bus_wr    <= 1'b0;
      bus_size  <= SIZE_W;
      bus_addr  <= inst_addr;
      bus_wdata <= 32'd0;
    end
  end

  // Pulses are steered to the owner only, and suppressed while reset is held
  assign inst_addr_ok = rst & w_addr_ok & (r_owner == OWN_INST);
  assign data_addr_ok = rst & w_addr_ok & (r_owner == OWN_DATA);
  assign inst_data_ok = rst & w_data_ok & (r_owner == OWN_INST);
  assign data_data_ok = rst & w_data_ok & (r_owner == OWN_DATA);

  assign inst_rdata = bus_rdata;
  assign data_rdata = bus_rdata;

  // A requester stalls while its access is pending, releasing on its data_ok cycle
  assign stallreq_from_if  = (inst_req | ((r_state != ARB_IDLE) & (r_owner == OWN_INST)))
                             & ~inst_data_ok;
  assign stallreq_from_mem = (data_req | ((r_state != ARB_IDLE) & (r_owner == OWN_DATA)))
                             & ~data_data_ok;

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_cpu_bus_arbiter
//  Purpose  : Self-checking bench for cpu_bus_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_bus_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;
  logic        stallreq_from_if, stallreq_from_mem;

  int checks   = 0;
  int failures = 0;

  cpu_bus_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata),
    .stallreq_from_if(stallreq_from_if), .stallreq_from_mem(stallreq_from_mem)
  );

  always #5 clk = ~clk;

  // Move to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 1'b0; inst_addr = 32'd0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'd0; data_wdata = 32'd0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'd0;
  endtask

  // Acts as the bus: waits for a request, accepts it, returns rdata; reports who got addr_ok
  task automatic do_txn(input logic [31:0] rdata, output bit got_data, output bit got_inst,
                        output bit timed_out);
    got_data = 1'b0; got_inst = 1'b0; timed_out = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(); #1;
      if (bus_req === 1'b1) begin timed_out = 1'b0; break; end
    end
    if (!timed_out) begin
      bus_addr_ok = 1'b1; #1;
      got_data = data_addr_ok; got_inst = inst_addr_ok;
      step(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = rdata; #1;
      step(); bus_data_ok = 1'b0; bus_rdata = 32'd0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h1234_5678;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd1; data_addr = 32'h8765_4320;
    data_wdata = 32'hCAFE_F00D; bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h5555_AAAA;
    step(); step(); #1;
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL reset_bus_req got=%b exp=0", bus_req); end
    checks++; if (bus_wr !== 1'b0) begin failures++; $display("FAIL reset_bus_wr got=%b exp=0", bus_wr); end
    checks++; if (bus_size !== 2'd0) begin failures++; $display("FAIL reset_bus_size got=%0d exp=0", bus_size); end
    checks++; if (bus_addr !== 32'd0) begin failures++; $display("FAIL reset_bus_addr got=%h exp=0", bus_addr); end
    checks++; if (bus_wdata !== 32'd0) begin failures++; $display("FAIL reset_bus_wdata got=%h exp=0", bus_wdata); end
    checks++; if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0000) begin
      failures++; $display("FAIL reset_oks got=%b exp=0000", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
    idle_inputs();
    rst = 1'b1;
    step(); step();
  endtask

  task automatic test_single_fetch();
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000; #1;                          // cycle 1
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL fetch_c1_bus_req got=%b exp=0", bus_req); end
    checks++; if (stallreq_from_if !== 1'b1) begin failures++; $display("FAIL fetch_c1_stall_if got=%b exp=1", stallreq_from_if); end
    step(); #1;                                                                // cycle 2
    checks++; if (bus_req !== 1'b1) begin failures++; $display("FAIL fetch_c2_bus_req got=%b exp=1", bus_req); end
    checks++; if ({bus_wr, bus_size, bus_addr} !== {1'b0, 2'd2, 32'hBFC0_0000}) begin
      failures++; $display("FAIL fetch_c2_fields got=%b/%0d/%h exp=0/2/bfc00000", bus_wr, bus_size, bus_addr); end
    checks++; if (inst_addr_ok !== 1'b0) begin failures++; $display("FAIL fetch_c2_addr_ok got=%b exp=0", inst_addr_ok); end
    step(); bus_addr_ok = 1'b1; #1;                                            // cycle 3
    checks++; if ({inst_addr_ok, data_addr_ok, bus_req} !== 3'b101) begin
      failures++; $display("FAIL fetch_c3_addr_ok got=%b exp=101", {inst_addr_ok, data_addr_ok, bus_req}); end
    step(); inst_req = 1'b0; bus_addr_ok = 1'b0; #1;                           // cycle 4
    checks++; if ({bus_req, stallreq_from_if} !== 2'b01) begin
      failures++; $display("FAIL fetch_c4_req_stall got=%b exp=01", {bus_req, stallreq_from_if}); end
    step(); bus_data_ok = 1'b1; bus_rdata = 32'h3C08_0001; #1;                 // cycle 5
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin
      failures++; $display("FAIL fetch_c5_data_ok got=%b exp=10", {inst_data_ok, data_data_ok}); end
    checks++; if (inst_rdata !== 32'h3C08_0001) begin failures++; $display("FAIL fetch_c5_rdata got=%h exp=3c080001", inst_rdata); end
    checks++; if (stallreq_from_if !== 1'b0) begin failures++; $display("FAIL fetch_c5_stall_if got=%b exp=0", stallreq_from_if); end
    step(); bus_data_ok = 1'b0; #1;
    checks++; if (inst_data_ok !== 1'b0) begin failures++; $display("FAIL fetch_c6_data_ok got=%b exp=0", inst_data_ok); end
  endtask

  task automatic test_simultaneous();
    step();
    inst_req = 1'b1; inst_addr = 32'hBFC0_0010;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h8000_1000; data_wdata = 32'hDEAD_BEEF;
    step(); #1;
    checks++; if ({bus_req, bus_wr, bus_size, bus_addr, bus_wdata} !== {1'b1, 1'b1, 2'd2, 32'h8000_1000, 32'hDEAD_BEEF}) begin
      failures++; $display("FAIL simul_data_fields got=%b/%b/%0d/%h/%h exp=1/1/2/80001000/deadbeef", bus_req, bus_wr, bus_size, bus_addr, bus_wdata); end
    bus_addr_ok = 1'b1; #1;
    checks++; if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin
      failures++; $display("FAIL simul_data_addr_ok got=%b exp=10", {data_addr_ok, inst_addr_ok}); end
    step(); data_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0; #1;
    checks++; if ({data_data_ok, inst_data_ok, stallreq_from_mem, stallreq_from_if} !== 4'b1001) begin
      failures++; $display("FAIL simul_data_done got=%b exp=1001", {data_data_ok, inst_data_ok, stallreq_from_mem, stallreq_from_if}); end
    step(); bus_data_ok = 1'b0; #1;
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL simul_idle_gap got=%b exp=0", bus_req); end
    step(); #1;
    checks++; if ({bus_req, bus_wr, bus_size, bus_addr, bus_wdata} !== {1'b1, 1'b0, 2'd2, 32'hBFC0_0010, 32'd0}) begin
      failures++; $display("FAIL simul_inst_fields got=%b/%b/%0d/%h/%h exp=1/0/2/bfc00010/0", bus_req, bus_wr, bus_size, bus_addr, bus_wdata); end
    bus_addr_ok = 1'b1; #1;
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin
      failures++; $display("FAIL simul_inst_addr_ok got=%b exp=10", {inst_addr_ok, data_addr_ok}); end
    step(); inst_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h2402_0005; #1;
    checks++; if ({inst_data_ok, inst_rdata} !== {1'b1, 32'h2402_0005}) begin
      failures++; $display("FAIL simul_inst_done got=%b/%h exp=1/24020005", inst_data_ok, inst_rdata); end
    step(); idle_inputs(); step();
  endtask

  task automatic test_starvation();
    bit exp_data [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    bit gd, gi, to;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0100;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_0000;
    for (int k = 0; k < 6; k++) begin
      do_txn(32'h1000 + k, gd, gi, to);
      checks++;
      if (to || gd !== exp_data[k] || gi !== !exp_data[k]) begin
        failures++; $display("FAIL starve_grant_%0d got data=%b inst=%b timeout=%b exp data=%b", k, gd, gi, to, exp_data[k]);
      end
    end
    idle_inputs(); step(); step();
  endtask

  task automatic test_byte_load();
    inst_req = 1'b0;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'h8000_0003;
    step(); #1;
    checks++; if ({bus_req, bus_wr, bus_size, bus_addr} !== {1'b1, 1'b0, 2'd0, 32'h8000_0003}) begin
      failures++; $display("FAIL byte_fields got=%b/%b/%0d/%h exp=1/0/0/80000003", bus_req, bus_wr, bus_size, bus_addr); end
    bus_addr_ok = 1'b1; #1;
    step(); data_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0000_00AB; #1;
    checks++; if ({data_data_ok, data_rdata, stallreq_from_mem} !== {1'b1, 32'h0000_00AB, 1'b0}) begin
      failures++; $display("FAIL byte_done got=%b/%h/%b exp=1/000000ab/0", data_data_ok, data_rdata, stallreq_from_mem); end
    step(); idle_inputs(); step();
  endtask

  task automatic test_reset_mid_data();
    inst_req = 1'b1; inst_addr = 32'hBFC0_0200;
    step(); bus_addr_ok = 1'b1; #1;
    step(); inst_req = 1'b0; bus_addr_ok = 1'b0; rst = 1'b0; #1;
    checks++; if (inst_data_ok !== 1'b0) begin failures++; $display("FAIL rstdata_in_reset got=%b exp=0", inst_data_ok); end
    step(); rst = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h7777_7777; #1;
    checks++; if ({bus_req, inst_data_ok, data_data_ok, stallreq_from_if} !== 4'b0000) begin
      failures++; $display("FAIL rstdata_stray_ok got=%b exp=0000", {bus_req, inst_data_ok, data_data_ok, stallreq_from_if}); end
    step(); bus_data_ok = 1'b0; inst_req = 1'b1; #1;
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL rstdata_idle got=%b exp=0", bus_req); end
    step(); #1;
    checks++; if (bus_req !== 1'b1) begin failures++; $display("FAIL rstdata_regrant got=%b exp=1", bus_req); end
    bus_addr_ok = 1'b1; #1;
    checks++; if (inst_addr_ok !== 1'b1) begin failures++; $display("FAIL rstdata_addr_ok got=%b exp=1", inst_addr_ok); end
    step(); inst_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; #1;
    step(); idle_inputs(); step();
  endtask

  task automatic test_stalled_addr();
    bit to;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd1; data_addr = 32'h8000_2002; data_wdata = 32'h0000_BEEF;
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(); #1;
      if (bus_req === 1'b1) begin to = 1'b0; break; end
    end
    checks++; if (to) begin failures++; $display("FAIL stall_wait_req got=timeout exp=bus_req"); end
    for (int i = 0; i < 10; i++) begin
      bus_data_ok = i[0];
      step(); #1;
      checks++;
      if ({bus_req, bus_size, bus_addr, data_addr_ok, data_data_ok} !== {1'b1, 2'd1, 32'h8000_2002, 1'b0, 1'b0}) begin
        failures++; $display("FAIL stall_hold_%0d got=%b/%0d/%h/%b/%b exp=1/1/80002002/0/0", i, bus_req, bus_size, bus_addr, data_addr_ok, data_data_ok);
      end
    end
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; #1;
    checks++; if ({data_addr_ok, data_data_ok} !== 2'b10) begin
      failures++; $display("FAIL stall_accept got=%b exp=10", {data_addr_ok, data_data_ok}); end
    step(); data_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; #1;
    step(); idle_inputs(); step();
  endtask

  // Transaction-level model: at most one access in flight; grants follow the
  // priority and starvation rules; the bus sees it until accepted, then it
  // completes on the first response.
  task automatic test_random(input int ncycles);
    bit          live, accepted, own_data;
    logic        m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    int          starve;
    bit          e_iaok, e_daok, e_idok, e_ddok, e_breq, e_sif, e_smem;
    bit          prev_iaok, prev_daok;
    live = 1'b0; accepted = 1'b0; own_data = 1'b0; starve = 0;
    m_wr = 1'b0; m_size = 2'd0; m_addr = 32'd0; m_wdata = 32'd0;
    prev_iaok = 1'b0; prev_daok = 1'b0;
    idle_inputs(); rst = 1'b0; step(); rst = 1'b1;
    for (int c = 0; c < ncycles; c++) begin
      step();
      if (!inst_req || prev_iaok) begin
        inst_req = ($urandom_range(0, 2) == 0); inst_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!data_req || prev_daok) begin
        data_req = ($urandom_range(0, 2) == 0); data_wr = $urandom_range(0, 1);
        data_size = 2'($urandom_range(0, 2)); data_addr = $urandom; data_wdata = $urandom;
      end
      bus_addr_ok = ($urandom_range(0, 2) == 0);
      bus_data_ok = ($urandom_range(0, 2) == 0);
      bus_rdata   = $urandom;
      rst         = ($urandom_range(0, 149) != 0);
      #1;
      e_breq = live && !accepted;
      e_iaok = rst && live && !accepted && !own_data && bus_addr_ok;
      e_daok = rst && live && !accepted &&  own_data && bus_addr_ok;
      e_idok = rst && live &&  accepted && !own_data && bus_data_ok;
      e_ddok = rst && live &&  accepted &&  own_data && bus_data_ok;
      e_sif  = (inst_req || (live && !own_data)) && !e_idok;
      e_smem = (data_req || (live &&  own_data)) && !e_ddok;
      checks++; if (bus_req !== e_breq) begin failures++; $display("FAIL rand_bus_req cyc=%0d got=%b exp=%b", c, bus_req, e_breq); end
      checks++; if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== {e_iaok, e_daok, e_idok, e_ddok}) begin
        failures++; $display("FAIL rand_oks cyc=%0d got=%b exp=%b", c, {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, {e_iaok, e_daok, e_idok, e_ddok}); end
      checks++; if ({stallreq_from_if, stallreq_from_mem} !== {e_sif, e_smem}) begin
        failures++; $display("FAIL rand_stalls cyc=%0d got=%b exp=%b", c, {stallreq_from_if, stallreq_from_mem}, {e_sif, e_smem}); end
      if (e_breq) begin
        checks++; if ({bus_wr, bus_size, bus_addr, bus_wdata} !== {m_wr, m_size, m_addr, m_wdata}) begin
          failures++; $display("FAIL rand_fields cyc=%0d got=%b/%0d/%h/%h exp=%b/%0d/%h/%h", c, bus_wr, bus_size, bus_addr, bus_wdata, m_wr, m_size, m_addr, m_wdata); end
      end
      if (e_idok) begin
        checks++; if (inst_rdata !== bus_rdata) begin failures++; $display("FAIL rand_inst_rdata cyc=%0d got=%h exp=%h", c, inst_rdata, bus_rdata); end
      end
      if (e_ddok) begin
        checks++; if (data_rdata !== bus_rdata) begin failures++; $display("FAIL rand_data_rdata cyc=%0d got=%h exp=%h", c, data_rdata, bus_rdata); end
      end
      prev_iaok = inst_addr_ok; prev_daok = data_addr_ok;
      // advance the model across the coming clock edge
      if (!rst) begin
        live = 1'b0; starve = 0;
      end else if (!live) begin
        if (data_req && !(inst_req && starve == LIMIT)) begin
          live = 1'b1; accepted = 1'b0; own_data = 1'b1;
          m_wr = data_wr; m_size = data_size; m_addr = data_addr; m_wdata = data_wdata;
          starve = inst_req ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
        end else if (inst_req) begin
          live = 1'b1; accepted = 1'b0; own_data = 1'b0;
          m_wr = 1'b0; m_size = 2'd2; m_addr = inst_addr; m_wdata = 32'd0;
          starve = 0;
        end else begin
          starve = 0;
        end
      end else if (!accepted) begin
        if (bus_addr_ok) accepted = 1'b1;
      end else if (bus_data_ok) begin
        live = 1'b0;
      end
    end
    rst = 1'b1; idle_inputs(); step();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_byte_load();
    test_reset_mid_data();
    test_stalled_addr();
    test_random(3000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
